// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// UART frame serialiser running on the divided TX bit clock (one i_clk cycle
// is one bit period). A byte presented with a single-cycle strobe while idle
// is sent as: start bit (0), DATA_WIDTH data bits LSB first, an optional
// parity bit, and one stop bit (1). Strobes that arrive mid-frame are dropped.
//
// Parameters
//   DATA_WIDTH    data bits per frame (5..9)
//
// Ports
//   i_clk         TX bit clock
//   i_rst_n       synchronous, active-low reset
//   i_p_data      parallel data to transmit
//   i_data_valid  single-cycle strobe qualifying i_p_data
//   i_par_en      1 = append a parity bit
//   i_par_typ     0 = even parity, 1 = odd parity
//   o_tx_out      serial line, idles high (registered)
//   o_busy        high while a frame is on the line (registered)
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_p_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic                  o_tx_out,
    output logic                  o_busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_reg,   state_next;
    logic [DATA_WIDTH-1:0]   shift_reg,   shift_next;
    logic [CNT_W-1:0]        cnt_reg,     cnt_next;
    logic                    par_en_reg,  par_en_next;
    logic                    par_bit_reg, par_bit_next;
    logic                    tx_reg,      tx_next;
    logic                    busy_reg,    busy_next;

    // Parity is computed from the input word at acceptance, so later changes
    // on i_p_data / i_par_typ cannot affect the frame. Seeding the XOR chain
    // with i_par_typ turns even parity into odd parity.
    logic [DATA_WIDTH:0] par_chain;
    assign par_chain[0] = i_par_typ;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_par_chain
            assign par_chain[gi+1] = par_chain[gi] ^ i_p_data[gi];
        end
    endgenerate

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            cnt_reg     <= cnt_next;
            par_en_reg  <= par_en_next;
            par_bit_reg <= par_bit_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
        end
    end

    // Next-state logic. tx_next/busy_next describe the line during the state
    // being entered, which keeps both outputs registered with no extra
    // cycle of latency.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        cnt_next     = cnt_reg;
        par_en_next  = par_en_reg;
        par_bit_next = par_bit_reg;
        tx_next      = 1'b1;
        busy_next    = 1'b1;

        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (i_data_valid) begin
                    state_next   = START;
                    shift_next   = i_p_data;
                    par_en_next  = i_par_en;
                    par_bit_next = par_chain[DATA_WIDTH];
                    tx_next      = 1'b0;
                    busy_next    = 1'b1;
                end
            end

            START: begin
                state_next = DATA;
                cnt_next   = '0;
                tx_next    = shift_reg[0];
                shift_next = shift_reg >> 1;
            end

            DATA: begin
                if (cnt_reg == LAST_BIT) begin
                    if (par_en_reg) begin
                        state_next = PARITY;
                        tx_next    = par_bit_reg;
                    end else begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end
                end else begin
                    // shift_reg[0] already holds bit cnt_reg+1
                    cnt_next   = cnt_reg + 1'b1;
                    tx_next    = shift_reg[0];
                    shift_next = shift_reg >> 1;
                end
            end

            PARITY: begin
                state_next = STOP;
                tx_next    = 1'b1;
            end

            STOP: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign o_tx_out = tx_reg;
    assign o_busy   = busy_reg;

endmodule
